// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for two 4-digit seven-segment groups (left/right).
// Frames are latched via load/ready and scanned one digit per slot with registered pins.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 100_000,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] digits,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  blink_mask,
    input  logic [1:0]  lz_blank,
    output logic        ready,
    output logic [7:0]  led_l,
    output logic [7:0]  led_r,
    output logic [3:0]  ena_l,
    output logic [3:0]  ena_r
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int BLK_W = $clog2(BLINK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  dp;
        logic [7:0]  blink;
        logic [1:0]  lz;
    } frame_t;

    localparam frame_t FRAME_RST = '{digits: 32'hFFFF_FFFF, dp: 8'h00, blink: 8'h00, lz: 2'b00};

    function automatic logic [7:0] seg_code(input logic [3:0] code);
        case (code)
            4'h0:    seg_code = 8'hFC;
            4'h1:    seg_code = 8'h60;
            4'h2:    seg_code = 8'hDA;
            4'h3:    seg_code = 8'hF2;
            4'h4:    seg_code = 8'h66;
            4'h5:    seg_code = 8'hB6;
            4'h6:    seg_code = 8'hBE;
            4'h7:    seg_code = 8'hE0;
            4'h8:    seg_code = 8'hFE;
            4'h9:    seg_code = 8'hF6;
            4'hA:    seg_code = 8'h02;
            4'hB:    seg_code = 8'h9E;
            4'hC:    seg_code = 8'h6E;
            4'hD:    seg_code = 8'h1C;
            4'hE:    seg_code = 8'hCE;
            default: seg_code = 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] nibble(input logic [15:0] grp, input logic [1:0] sel);
        case (sel)
            2'd0:    nibble = grp[3:0];
            2'd1:    nibble = grp[7:4];
            2'd2:    nibble = grp[11:8];
            2'd3:    nibble = grp[15:12];
            default: nibble = 4'h0;
        endcase
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] sel);
        case (sel)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
    endfunction

    // A digit is a leading zero only while every more-significant digit is also zero.
    function automatic logic [3:0] lz_mask(input logic [15:0] grp, input logic en);
        logic b3;
        logic b2;
        logic b1;
        b3 = en && (grp[15:12] == 4'h0);
        b2 = b3 && (grp[11:8] == 4'h0);
        b1 = b2 && (grp[7:4] == 4'h0);
        lz_mask = {b3, b2, b1, 1'b0};
    endfunction

    function automatic logic [7:0] digit_led(input logic [15:0] grp, input logic [1:0] sel,
                                             input logic [3:0] dp4, input logic [3:0] blink4,
                                             input logic lz_en, input logic phase);
        logic [3:0] lzm;
        logic       blank;
        lzm   = lz_mask(grp, lz_en);
        blank = lzm[sel] || (phase && blink4[sel]);
        if (blank) begin
            digit_led = 8'h00;
        end else begin
            digit_led = seg_code(nibble(grp, sel)) | {7'b0000000, dp4[sel]};
        end
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             phase_q, phase_d;
    logic             ready_q, ready_d;
    frame_t           pend_q, pend_d;
    frame_t           act_q, act_d;
    logic [7:0]       led_l_q, led_l_d;
    logic [7:0]       led_r_q, led_r_d;
    logic [3:0]       ena_l_q, ena_l_d;
    logic [3:0]       ena_r_q, ena_r_d;
    logic             div_term_s;

    // Next-state: slot divider, blink phase, frame handshake and segment decode.
    always_comb begin
        div_d      = div_q;
        idx_d      = idx_q;
        blk_cnt_d  = blk_cnt_q;
        phase_d    = phase_q;
        ready_d    = ready_q;
        pend_d     = pend_q;
        act_d      = act_q;
        div_term_s = (div_q == DIV_LAST);

        if (div_term_s) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            div_d = div_q + DIV_W'(1);
            idx_d = idx_q;
        end

        if (blk_cnt_q == BLK_LAST) begin
            blk_cnt_d = '0;
            phase_d   = ~phase_q;
        end else begin
            blk_cnt_d = blk_cnt_q + BLK_W'(1);
            phase_d   = phase_q;
        end

        // ready low means a pending frame waits for the next slot boundary.
        if (ready_q) begin
            if (load) begin
                pend_d  = '{digits: digits, dp: dp_mask, blink: blink_mask, lz: lz_blank};
                ready_d = 1'b0;
            end else begin
                pend_d  = pend_q;
                ready_d = 1'b1;
            end
        end else if (div_term_s) begin
            act_d   = pend_q;
            ready_d = 1'b1;
        end else begin
            act_d   = act_q;
            ready_d = 1'b0;
        end

        led_r_d = digit_led(act_q.digits[15:0], idx_q, act_q.dp[3:0], act_q.blink[3:0],
                            act_q.lz[0], phase_q);
        led_l_d = digit_led(act_q.digits[31:16], idx_q, act_q.dp[7:4], act_q.blink[7:4],
                            act_q.lz[1], phase_q);
        ena_r_d = onehot(idx_q);
        ena_l_d = onehot(idx_q);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            idx_q     <= 2'd0;
            blk_cnt_q <= '0;
            phase_q   <= 1'b0;
            ready_q   <= 1'b1;
            pend_q    <= FRAME_RST;
            act_q     <= FRAME_RST;
            led_l_q   <= 8'h00;
            led_r_q   <= 8'h00;
            ena_l_q   <= 4'b0000;
            ena_r_q   <= 4'b0000;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            blk_cnt_q <= blk_cnt_d;
            phase_q   <= phase_d;
            ready_q   <= ready_d;
            pend_q    <= pend_d;
            act_q     <= act_d;
            led_l_q   <= led_l_d;
            led_r_q   <= led_r_d;
            ena_l_q   <= ena_l_d;
            ena_r_q   <= ena_r_d;
        end
    end

    assign ready = ready_q;
    assign led_l = led_l_q;
    assign led_r = led_r_q;
    assign ena_l = ena_l_q;
    assign ena_r = ena_r_q;

endmodule
